// File: rtl/zaap_sequencer.sv
// Launch sequencer for the PUF -> HD transform -> map key-generation pipeline.
// Build option: define ZAAP_SEQ_TIMEOUT_EN to add the per-stage wait watchdog (err_code 01/10).
module zaap_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAP_CYCLES     = 4,
    parameter int GAP_CYCLES     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       done_puf,
    input  logic       done_hd,
    output logic       enable_puf,
    output logic       enable_hd,
    output logic       enable_map,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [2:0] stage,
    output logic [3:0] state_dbg
);

    // Handshake: every enable_* is a one-cycle launch strobe with no back-pressure; a stage
    // completes on the first rising edge of its done_* sampled while its WAIT state is active.

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end
    if (MAP_CYCLES < 1) begin : g_bad_map
        $error("MAP_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 0");
    end

    localparam int CNT_MAX = (GAP_CYCLES > MAP_CYCLES) ? GAP_CYCLES : MAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] MAP_LAST = CW'(MAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PUF_GO   = 4'd1,
        S_PUF_WAIT = 4'd2,
        S_GAP_HD   = 4'd3,
        S_HD_GO    = 4'd4,
        S_HD_WAIT  = 4'd5,
        S_GAP_MAP  = 4'd6,
        S_MAP_GO   = 4'd7,
        S_MAP_WAIT = 4'd8,
        S_DONE     = 4'd9,
        S_ERR      = 4'd10
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_d;
    logic          puf_prev, hd_prev;
    logic          puf_edge, hd_edge;
    logic [1:0]    err_cause;

    logic       enable_puf_d, enable_hd_d, enable_map_d;
    logic       busy_d, done_d, error_d;
    logic [1:0] err_code_d;
    logic [2:0] stage_d;

`ifdef ZAAP_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt, to_cnt_d;
    logic          to_expired;

    assign to_expired = (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_d;
        end
    end
`endif

    // A level left high from an earlier run has prev=1 and therefore never looks like completion.
    assign puf_edge  = done_puf & ~puf_prev;
    assign hd_edge   = done_hd & ~hd_prev;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            puf_prev   <= 1'b0;
            hd_prev    <= 1'b0;
            enable_puf <= 1'b0;
            enable_hd  <= 1'b0;
            enable_map <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
            stage      <= 3'd0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_d;
            puf_prev   <= done_puf;
            hd_prev    <= done_hd;
            enable_puf <= enable_puf_d;
            enable_hd  <= enable_hd_d;
            enable_map <= enable_map_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            err_code   <= err_code_d;
            stage      <= stage_d;
        end
    end

    always_comb begin
        next_state = state;
        err_cause  = 2'b00;
        case (state)
            S_IDLE:  if (start && !abort) next_state = S_PUF_GO;
            S_ERR:   if (start && !abort) next_state = S_PUF_GO;
            S_DONE:  next_state = S_IDLE;
            default: begin
                if (abort) begin
                    next_state = S_ERR;
                    err_cause  = 2'b11;
                end else begin
                    case (state)
                        S_PUF_GO: next_state = S_PUF_WAIT;
                        S_PUF_WAIT: begin
                            // Completion outranks a simultaneous watchdog expiry.
                            if (puf_edge) begin
                                next_state = (GAP_CYCLES == 0) ? S_HD_GO : S_GAP_HD;
                            end
`ifdef ZAAP_SEQ_TIMEOUT_EN
                            else if (to_expired) begin
                                next_state = S_ERR;
                                err_cause  = 2'b01;
                            end
`endif
                        end
                        S_GAP_HD: if (cnt == GAP_LAST) next_state = S_HD_GO;
                        S_HD_GO:  next_state = S_HD_WAIT;
                        S_HD_WAIT: begin
                            if (hd_edge) begin
                                next_state = (GAP_CYCLES == 0) ? S_MAP_GO : S_GAP_MAP;
                            end
`ifdef ZAAP_SEQ_TIMEOUT_EN
                            else if (to_expired) begin
                                next_state = S_ERR;
                                err_cause  = 2'b10;
                            end
`endif
                        end
                        S_GAP_MAP:  if (cnt == GAP_LAST) next_state = S_MAP_GO;
                        S_MAP_GO:   next_state = S_MAP_WAIT;
                        S_MAP_WAIT: if (cnt == MAP_LAST) next_state = S_DONE;
                        default:    next_state = S_IDLE;
                    endcase
                end
            end
        endcase

        cnt_d = '0;
        if ((next_state == state) &&
            (state == S_GAP_HD || state == S_GAP_MAP || state == S_MAP_WAIT)) begin
            cnt_d = cnt + CW'(1);
        end
`ifdef ZAAP_SEQ_TIMEOUT_EN
        to_cnt_d = '0;
        if ((next_state == state) && (state == S_PUF_WAIT || state == S_HD_WAIT)) begin
            to_cnt_d = to_cnt + TW'(1);
        end
`endif
    end

    // Outputs are decoded from the upcoming state so they change at the same edge as the state.
    always_comb begin
        enable_puf_d = (next_state == S_PUF_GO);
        enable_hd_d  = (next_state == S_HD_GO);
        enable_map_d = (next_state == S_MAP_GO);
        done_d       = (next_state == S_DONE);
        error_d      = (next_state == S_ERR);
        busy_d       = !(next_state inside {S_IDLE, S_DONE, S_ERR});
        err_code_d   = 2'b00;
        if (next_state == S_ERR) begin
            err_code_d = (state == S_ERR) ? err_code : err_cause;
        end
        stage_d = 3'd0;
        case (next_state)
            S_PUF_GO, S_PUF_WAIT:            stage_d = 3'd1;
            S_GAP_HD, S_HD_GO, S_HD_WAIT:    stage_d = 3'd2;
            S_GAP_MAP, S_MAP_GO, S_MAP_WAIT: stage_d = 3'd3;
            S_DONE:                          stage_d = 3'd4;
            S_ERR:                           stage_d = 3'd7;
            default:                         stage_d = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_zaap_sequencer.sv
// Directed bench for zaap_sequencer: per-cycle check against a stage-timeline model plus
// hand-computed launch/completion spacings held in an expected queue.
module tb_zaap_sequencer;

    localparam int T_CYC = 16;
    localparam int MAP_C = 4;
    localparam int GAP_C = 1;
`ifdef ZAAP_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int W_PUF  = 0;
    localparam int W_HD   = 1;
    localparam int W_MAP  = 2;
    localparam int W_DONE = 3;
    localparam int W_ERR  = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       done_puf = 1'b0;
    logic       done_hd = 1'b0;
    logic       enable_puf, enable_hd, enable_map, busy, done, error;
    logic [1:0] err_code;
    logic [2:0] stage;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    zaap_sequencer #(
        .TIMEOUT_CYCLES(T_CYC),
        .MAP_CYCLES    (MAP_C),
        .GAP_CYCLES    (GAP_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .done_puf  (done_puf),
        .done_hd   (done_hd),
        .enable_puf(enable_puf),
        .enable_hd (enable_hd),
        .enable_map(enable_map),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .stage     (stage),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_next(input string name, input int act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected queue empty, got %0d", name, act);
        end else begin
            check(name, act, int'(exp_q.pop_front()));
        end
    endtask

    // ---------------- stage-timeline model ----------------
    // m_mode: 0 idle, 1 PUF stage, 2 HD stage (incl. gap), 3 map stage (incl. gap), 4 done cycle, 7 error
    int   m_mode = 0;
    int   m_code = 0;
    int   go_puf = -1, go_hd = -1, go_map = -1, done_at = -1, wait_from = 0;
    logic pp = 1'b0, hp = 1'b0;
    int   n_puf = 0, n_hd = 0, n_map = 0, n_done = 0;

    task automatic model_reset();
        m_mode = 0; m_code = 0;
        go_puf = -1; go_hd = -1; go_map = -1; done_at = -1; wait_from = 0;
        pp = 1'b0; hp = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic dp, input logic dh);
        int c;
        c = cyc;
        if (m_mode == 4) begin
            m_mode = 0;
        end else if (m_mode == 0 || m_mode == 7) begin
            if (s && !a) begin
                m_mode = 1; m_code = 0;
                go_puf = c; go_hd = -1; go_map = -1; done_at = -1;
                wait_from = c + 1;
            end
        end else if (a) begin
            m_mode = 7; m_code = 3;
            go_hd = -1; go_map = -1; done_at = -1;
        end else if (m_mode == 1) begin
            if (c - 1 >= wait_from) begin
                if (dp && !pp) begin
                    go_hd = c + GAP_C; wait_from = go_hd + 1; m_mode = 2;
                end else if (TO_EN && (c - 1 - wait_from == T_CYC - 1)) begin
                    m_mode = 7; m_code = 1;
                end
            end
        end else if (m_mode == 2) begin
            if (c - 1 >= wait_from) begin
                if (dh && !hp) begin
                    go_map = c + GAP_C; done_at = go_map + MAP_C + 1; m_mode = 3;
                end else if (TO_EN && (c - 1 - wait_from == T_CYC - 1)) begin
                    m_mode = 7; m_code = 2;
                end
            end
        end else if (m_mode == 3) begin
            if (c == done_at) m_mode = 4;
        end
        pp = dp;
        hp = dh;
    endtask

    task automatic compare();
        check("enable_puf", int'(enable_puf), int'(go_puf == cyc));
        check("enable_hd",  int'(enable_hd),  int'(go_hd == cyc));
        check("enable_map", int'(enable_map), int'(go_map == cyc));
        check("busy",       int'(busy),       int'(m_mode >= 1 && m_mode <= 3));
        check("done",       int'(done),       int'(m_mode == 4));
        check("error",      int'(error),      int'(m_mode == 7));
        check("err_code",   int'(err_code),   (m_mode == 7) ? m_code : 0);
        check("stage",      int'(stage),      m_mode);
        if (enable_puf) n_puf++;
        if (enable_hd)  n_hd++;
        if (enable_map) n_map++;
        if (done)       n_done++;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) model_reset();
        else      model_step(start, abort, done_puf, done_hd);
        #1;
        if (rst) compare();
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sel(input int which);
        case (which)
            W_PUF:   return enable_puf;
            W_HD:    return enable_hd;
            W_MAP:   return enable_map;
            W_DONE:  return done;
            W_ERR:   return error;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_out(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_out_%0d: no event within %0d cycles", which, budget);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int k, h, p, d, e, k2;
    int b_puf, b_hd, b_map, b_done;

    task automatic snap();
        b_puf = n_puf; b_hd = n_hd; b_map = n_map; b_done = n_done;
    endtask

    initial begin
        // reset state
        tick(3);
        check("reset_outputs", int'({enable_puf, enable_hd, enable_map, busy, done, error, err_code, stage}), 0);
        check("reset_state", int'(state_dbg), 0);
        rst = 1'b1;
        tick(2);

        // nominal run: done_puf 7 cycles after enable_puf, done_hd 12 after enable_hd
        snap();
        exp_q.push_back(8'd8); exp_q.push_back(8'd13); exp_q.push_back(8'd5);
        pulse_start();
        wait_out(W_PUF, 4, k);
        tick(6); done_puf = 1'b1;
        wait_out(W_HD, 40, h);
        done_puf = 1'b0;
        expect_next("nom_hd_after_enable_puf", h - k);
        tick(11); done_hd = 1'b1;
        wait_out(W_MAP, 40, p);
        done_hd = 1'b0;
        expect_next("nom_map_after_enable_hd", p - h);
        wait_out(W_DONE, 20, d);
        expect_next("nom_done_after_enable_map", d - p);
        tick(2);
        check("nom_pulse_counts", (n_puf - b_puf) * 1000 + (n_hd - b_hd) * 100 + (n_map - b_map) * 10 + (n_done - b_done), 1111);

        // abort alone, then abort with start, in IDLE: both ignored
        snap();
        pulse_abort();
        tick(2);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #2 start = 1'b0; abort = 1'b0;
        tick(3);
        check("idle_ignore_busy", int'(busy), 0);
        check("idle_ignore_launch", n_puf - b_puf, 0);

        // stale done_puf held from before start
        snap();
        exp_q.push_back(8'd13);
        done_puf = 1'b1;
        tick(2);
        pulse_start();
        wait_out(W_PUF, 4, k);
        tick(9); done_puf = 1'b0;
        tick(2); done_puf = 1'b1;
        wait_out(W_HD, 30, h);
        done_puf = 1'b0;
        expect_next("stale_hd_after_rerise", h - k);
        tick(2); done_hd = 1'b1;
        wait_out(W_MAP, 20, p);
        done_hd = 1'b0;
        wait_out(W_DONE, 20, d);
        tick(1);
        check("stale_done_count", n_done - b_done, 1);

        // completion edge on the watchdog expiry cycle: edge wins
        exp_q.push_back(8'd18);
        pulse_start();
        wait_out(W_PUF, 4, k);
        tick(16); done_puf = 1'b1;
        wait_out(W_HD, 30, h);
        done_puf = 1'b0;
        expect_next("tie_hd_after_enable_puf", h - k);
        check("tie_error", int'(error), 0);
        tick(1); done_hd = 1'b1;
        wait_out(W_MAP, 20, p);
        done_hd = 1'b0;
        wait_out(W_DONE, 20, d);
        tick(2);

`ifdef ZAAP_SEQ_TIMEOUT_EN
        // HD timeout: done_hd never rises
        snap();
        exp_q.push_back(8'd17); exp_q.push_back(8'd1);
        pulse_start();
        wait_out(W_PUF, 4, k);
        tick(2); done_puf = 1'b1;
        wait_out(W_HD, 20, h);
        done_puf = 1'b0;
        wait_out(W_ERR, 40, e);
        expect_next("to_error_after_enable_hd", e - h);
        check("to_err_code", int'(err_code), 2);
        check("to_stage", int'(stage), 7);
        check("to_no_map", n_map - b_map, 0);
        pulse_start();
        wait_out(W_PUF, 4, k2);
        expect_next("to_restart_latency", k2 - e);
        check("to_restart_error", int'(error), 0);
        check("to_restart_err_code", int'(err_code), 0);
        pulse_abort();
        tick(2);
`endif

        // abort in MAP_WAIT, with a second start while busy
        snap();
        exp_q.push_back(8'd3);
        pulse_start();
        wait_out(W_PUF, 4, k);
        tick(1); done_puf = 1'b1;
        wait_out(W_HD, 20, h);
        done_puf = 1'b0;
        pulse_start();
        tick(1); done_hd = 1'b1;
        wait_out(W_MAP, 20, p);
        done_hd = 1'b0;
        tick(2);
        pulse_abort();
        wait_out(W_ERR, 4, e);
        expect_next("abort_error_after_enable_map", e - p);
        check("abort_err_code", int'(err_code), 3);
        check("abort_stage", int'(stage), 7);
        tick(MAP_C + 3);
        check("abort_no_done", n_done - b_done, 0);
        check("abort_second_start_ignored", n_puf - b_puf, 1);

        // asynchronous reset in HD wait, then a clean run
        pulse_start();
        wait_out(W_PUF, 4, k);
        tick(1); done_puf = 1'b1;
        wait_out(W_HD, 20, h);
        done_puf = 1'b0;
        tick(3);
        #2 rst = 1'b0;
        #1;
        check("midrst_outputs", int'({enable_puf, enable_hd, enable_map, busy, done, error, err_code, stage}), 0);
        check("midrst_state", int'(state_dbg), 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        snap();
        exp_q.push_back(8'd4); exp_q.push_back(8'd5);
        pulse_start();
        wait_out(W_PUF, 4, k);
        tick(2); done_puf = 1'b1;
        wait_out(W_HD, 20, h);
        done_puf = 1'b0;
        expect_next("postrst_hd_after_enable_puf", h - k);
        tick(2); done_hd = 1'b1;
        wait_out(W_MAP, 20, p);
        done_hd = 1'b0;
        wait_out(W_DONE, 20, d);
        expect_next("postrst_done_after_enable_map", d - p);
        tick(2);
        check("postrst_pulse_counts", (n_puf - b_puf) * 1000 + (n_hd - b_hd) * 100 + (n_map - b_map) * 10 + (n_done - b_done), 1111);
        check("postrst_error", int'(error), 0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
